even_odd_merge_sort4: RTL and testbench

//  4-input, 8-bit sorting block built on Batcher's odd-even merge network.

---
 rtl/even_odd_merge_sort4.sv | 104 ++++++++++
 tb/tb_even_odd_merge_sort4.sv | 123 ++++++++++++
 2 files changed

// File: rtl/even_odd_merge_sort4.sv
// Four-operand unsigned sort stage built on Batcher's odd-even merge network.
// Inputs are registered, sorted combinationally, and the results registered: 2-cycle latency, 1 set/cycle.

module even_odd_ce #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    logic swap;

    // Equal operands do not swap; their order is irrelevant downstream.
    assign swap = (x > y);
    assign lo   = swap ? y : x;
    assign hi   = swap ? x : y;
endmodule

module even_odd_merge_sort4 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [DATA_WIDTH-1:0] C,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] max,
    output logic [DATA_WIDTH-1:0] second_max,
    output logic [DATA_WIDTH-1:0] second_min,
    output logic [DATA_WIDTH-1:0] min
);
    localparam int NUM_OPS = 4;
    localparam int HALF    = NUM_OPS / 2;

    logic [NUM_OPS-1:0][DATA_WIDTH-1:0] in_q;
    logic [HALF-1:0][DATA_WIDTH-1:0]    l1_lo, l1_hi;
    logic [DATA_WIDTH-1:0]              l2_min, l2_m0, l2_m1, l2_max;
    logic [DATA_WIDTH-1:0]              l3_lo, l3_hi;

    // Stage 0: operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= '0;
        end else begin
            in_q[0] <= A;
            in_q[1] <= B;
            in_q[2] <= C;
            in_q[3] <= D;
        end
    end

    // Level 1: sort each pair (A,B) and (C,D).
    genvar i;
    generate
        for (i = 0; i < HALF; i++) begin : g_l1
            even_odd_ce #(.W(DATA_WIDTH)) u_ce (
                .x  (in_q[2*i]),
                .y  (in_q[2*i+1]),
                .lo (l1_lo[i]),
                .hi (l1_hi[i])
            );
        end
    endgenerate

    // Level 2: merge the sorted pairs; extremes are final after this level.
    even_odd_ce #(.W(DATA_WIDTH)) u_ce_lo (
        .x  (l1_lo[0]),
        .y  (l1_lo[1]),
        .lo (l2_min),
        .hi (l2_m0)
    );

    even_odd_ce #(.W(DATA_WIDTH)) u_ce_hi (
        .x  (l1_hi[0]),
        .y  (l1_hi[1]),
        .lo (l2_m1),
        .hi (l2_max)
    );

    // Level 3: the two middle candidates may still be out of order.
    even_odd_ce #(.W(DATA_WIDTH)) u_ce_mid (
        .x  (l2_m0),
        .y  (l2_m1),
        .lo (l3_lo),
        .hi (l3_hi)
    );

    // Stage 2: result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max        <= '0;
            second_max <= '0;
            second_min <= '0;
            min        <= '0;
        end else begin
            max        <= l2_max;
            second_max <= l3_hi;
            second_min <= l3_lo;
            min        <= l2_min;
        end
    end
endmodule

// File: tb/tb_even_odd_merge_sort4.sv
// Scoreboard bench for even_odd_merge_sort4: reference-sorted sets are queued on drive and
// compared two cycles later; covers reset, directed corners, a random stream and mid-stream reset.

module tb_even_odd_merge_sort4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A = '0, B = '0, C = '0, D = '0;
    logic [7:0] max, second_max, second_min, min;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    even_odd_merge_sort4 #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .max        (max),
        .second_max (second_max),
        .second_min (second_min),
        .min        (min)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    endtask

    // Reference: insertion sort, packed as {max, second_max, second_min, min}.
    function automatic logic [31:0] ref_sort(input logic [7:0] a, b, c, d);
        logic [7:0] v[4];
        logic [7:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0; j--)
                if (v[j] > v[j-1]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [31:0] outs();
        return {max, second_max, second_min, min};
    endfunction

    // One cycle: check the set driven two negedges ago, then drive and queue a new one.
    task automatic step(input string tag, input logic [7:0] a, b, c, d);
        @(negedge clk);
        if (sb_q.size() >= 2) chk(tag, outs(), sb_q.pop_front());
        A = a; B = b; C = c; D = d;
        sb_q.push_back(ref_sort(a, b, c, d));
    endtask

    // Inputs are zero while reset is released, so the first two outputs are zero.
    task automatic release_rst();
        @(negedge clk);
        A = '0; B = '0; C = '0; D = '0;
        rst = 1'b0;
        sb_q.delete();
        sb_q.push_back('0);
        sb_q.push_back('0);
    endtask

    initial begin
        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold", outs(), 32'h0);
        end
        release_rst();

        step("desc",   8'h04, 8'h03, 8'h02, 8'h01);
        step("wc_mix", 8'h10, 8'hFF, 8'h00, 8'h80);
        step("asc",    8'h01, 8'h02, 8'h03, 8'h04);
        step("all_eq", 8'h55, 8'h55, 8'h55, 8'h55);
        step("pairs",  8'h07, 8'h07, 8'h01, 8'h01);
        step("bounds", 8'hFF, 8'h00, 8'hFF, 8'h00);

        // 30-vector back-to-back stream.
        for (int k = 0; k < 30; k++)
            step("stream", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Asynchronous reset in the middle of the stream.
        step("pre_rst", 8'hA0, 8'h0B, 8'hC0, 8'h0D);
        #2 rst = 1'b1;
        #1 chk("rst_async", outs(), 32'h0);
        @(negedge clk);
        chk("rst_mid_hold", outs(), 32'h0);
        release_rst();

        step("post_a", 8'h09, 8'h30, 8'h21, 8'hFE);
        step("post_b", 8'h80, 8'h7F, 8'h81, 8'h7E);
        for (int k = 0; k < 8; k++)
            step("post_stream", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Drain the scoreboard.
        step("drain", 8'h00, 8'h00, 8'h00, 8'h00);
        step("drain", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Ordering invariant on every non-reset cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!(min <= second_min && second_min <= second_max && second_max <= max))
                chk("order_inv", outs(), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
